vga_axil_master_fsm: RTL and testbench
======================================

VGA_AXIL_MASTER_FSM -- requirements
Module: vga_axil_master_fsm

Interface
REQ-001 SHALL have parameter CHECK_ALIGN, default 1; when 1, misaligned requests are rejected locally.
REQ-002 SHALL have port clk_i, input, 1, sole clock; axil_if is clocked by the same clock.
REQ-003 SHALL have port arst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port axil_if, interface, vga_axil_if master modport, AXI-Lite initiator channels AW/W/B/AR/R.
REQ-005 SHALL have port req_valid_i, input, 1, native request valid.
REQ-006 SHALL have port req_ready_o, output, 1, module can accept a request.
REQ-007 SHALL have port req_write_i, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i, input, axil_addr_t, byte address.
REQ-009 SHALL have port req_data_i, input, axil_data_t, write data.
REQ-010 SHALL have port rsp_valid_o, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_write_o, output, 1, completed transaction was a write.
REQ-012 SHALL have port rsp_data_o, output, axil_data_t, read data; 0 for writes.
REQ-013 SHALL have port rsp_resp_o, output, axil_resp_e, BRESP/RRESP or local SLVERR.

Function
REQ-014 SHALL keep at most one transaction outstanding; req_ready_o = 1 only in IDLE.
REQ-015 SHALL use states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-016 Request handshake (req_valid_i & req_ready_o) in cycle N SHALL register addr/data/write; write -> WR_ADDR_DATA, read -> RD_ADDR; AWVALID/WVALID or ARVALID SHALL be high from cycle N+1.
REQ-017 WR_ADDR_DATA SHALL assert AWVALID and WVALID together, drop each independently after its own handshake, and move to WR_RESP once both have completed, including completion in the same cycle.
REQ-018 WSTRB SHALL be all ones; AWPROT/ARPROT SHALL be 0.
REQ-019 A VALID signal SHALL never drop before its handshake, and AWADDR/WDATA/ARADDR SHALL be stable while VALID is high.
REQ-020 WR_RESP SHALL hold BREADY = 1; on the B handshake it SHALL capture BRESP and go to DONE.
REQ-021 RD_ADDR SHALL assert ARVALID until the AR handshake, then go to RD_DATA.
REQ-022 RD_DATA SHALL hold RREADY = 1; on the R handshake it SHALL capture RDATA/RRESP and go to DONE.
REQ-023 BREADY/RREADY SHALL be 0 outside WR_RESP/RD_DATA.
REQ-024 DONE SHALL drive rsp_valid_o = 1 for exactly one cycle with registered rsp_* values, then return to IDLE.
REQ-025 With CHECK_ALIGN = 1 and req_addr_i[AXIL_WIDTH_OFFSET-1:0] != 0, it SHALL issue no bus transaction and go directly to DONE with rsp_resp_o = SLVERR and rsp_data_o = 0.
REQ-026 Minimum request-to-rsp latency with an always-ready slave SHALL be 3 cycles for writes and 3 cycles for reads (issue, handshake, response capture, DONE pulse).
REQ-027 rsp_* SHALL hold their last values outside DONE; rsp_valid_o is the only qualifier.

Reset
REQ-028 Asserting arst_n_i SHALL immediately force state IDLE, all AXI VALID/READY outputs 0, rsp_valid_o 0, rsp_data_o 0, rsp_resp_o OKAY, rsp_write_o 0, and addresses/data 0.
REQ-029 req_ready_o SHALL be 1 while in reset; reset mid-transaction SHALL abort it with no rsp pulse.

Structure
REQ-030 axil_addr_t, axil_data_t, axil_resp_e, AXIL_ADDR_WIDTH and AXIL_WIDTH_OFFSET SHALL come from vga_axil_pkg; the state enum SHALL be local to the module.
REQ-031 It SHALL be one flat module with no sub-modules; companion assertions SHALL go in vga_axil_master_fsm_sva, bound to the module.

Verification
REQ-032 Write addr 0x10, data 0xDEADBEEF, slave always ready, BRESP OKAY -> AW/W seen with 0x10/0xDEADBEEF, then one rsp pulse with rsp_write_o = 1 and resp OKAY, 3 cycles after acceptance.
REQ-033 Write, then read addr 0x10 to a memory-model slave -> rsp_data_o = 0xDEADBEEF, resp OKAY, rsp_write_o = 0.
REQ-034 AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held stable 4 cycles, exactly one B is accepted.
REQ-035 Read addr 0x13 with CHECK_ALIGN = 1 -> no ARVALID, rsp SLVERR with data 0 on the cycle after acceptance.
REQ-036 Slave returns RRESP SLVERR for addr 0x20 -> rsp_resp_o = SLVERR.
REQ-037 arst_n_i asserted while in WR_RESP -> all valids 0, no rsp pulse, req_ready_o = 1, and the next request completes normally.

Source files
------------

// File: rtl/vga_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_pkg
// Description : Shared AXI4-Lite widths, types and response encodings for the
//               VGA register-access fabric.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_axil_pkg;

  localparam int AXIL_ADDR_WIDTH   = 32;
  localparam int AXIL_DATA_WIDTH   = 32;
  localparam int AXIL_STRB_WIDTH   = AXIL_DATA_WIDTH / 8;
  // Number of byte-offset address bits inside one data word.
  localparam int AXIL_WIDTH_OFFSET = $clog2(AXIL_STRB_WIDTH);

  typedef logic [AXIL_ADDR_WIDTH-1:0] axil_addr_t;
  typedef logic [AXIL_DATA_WIDTH-1:0] axil_data_t;
  typedef logic [AXIL_STRB_WIDTH-1:0] axil_strb_t;
  typedef logic [2:0]                 axil_prot_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

endpackage : vga_axil_pkg
`default_nettype wire

// File: rtl/vga_axil_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_if
// Description : AXI4-Lite channel bundle (AW/W/B/AR/R). Clocked by the clock
//               of whichever master/slave pair it connects.
// Ports       : none (signal bundle only)
//   modport master : drives AW/W/AR payload+valid, BREADY, RREADY
//   modport slave  : drives AWREADY/WREADY/ARREADY, B and R payload+valid
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_axil_if;
  import vga_axil_pkg::*;

  logic       awvalid;
  logic       awready;
  axil_addr_t awaddr;
  axil_prot_t awprot;

  logic       wvalid;
  logic       wready;
  axil_data_t wdata;
  axil_strb_t wstrb;

  logic       bvalid;
  logic       bready;
  axil_resp_e bresp;

  logic       arvalid;
  logic       arready;
  axil_addr_t araddr;
  axil_prot_t arprot;

  logic       rvalid;
  logic       rready;
  axil_data_t rdata;
  axil_resp_e rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface : vga_axil_if
`default_nettype wire

// File: rtl/vga_axil_master_fsm_sva.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_master_fsm_sva
// Description : Protocol properties for vga_axil_master_fsm, attached with a
//               bind so the design itself stays a single flat module.
// Ports       :
//   clk_i, arst_n_i            clock and asynchronous active-low reset
//   awvalid/awready            AW handshake
//   wvalid/wready              W handshake
//   arvalid/arready            AR handshake
//   bready/rready              response-channel readies
//   addr, data                 held request address / write data
//   rsp_valid                  completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_master_fsm_sva
  import vga_axil_pkg::*;
(
  input logic       clk_i,
  input logic       arst_n_i,
  input logic       awvalid,
  input logic       awready,
  input logic       wvalid,
  input logic       wready,
  input logic       arvalid,
  input logic       arready,
  input logic       bready,
  input logic       rready,
  input axil_addr_t addr,
  input axil_data_t data,
  input logic       rsp_valid
);

  // A pending VALID stays up with a stable payload until its handshake.
  a_aw_hold: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (awvalid && !awready) |=> (awvalid && $stable(addr)));

  a_w_hold: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (wvalid && !wready) |=> (wvalid && $stable(data)));

  a_ar_hold: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (arvalid && !arready) |=> (arvalid && $stable(addr)));

  // Only one transaction in flight: never a read and a write together.
  a_single_txn: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    !((awvalid || wvalid) && arvalid));

  a_ready_excl: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    !(bready && rready));

  // Response readies are only raised once the request channels are idle.
  a_bready_quiet: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    bready |-> !(awvalid || wvalid || arvalid));

  a_rsp_pulse: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    rsp_valid |=> !rsp_valid);

endmodule : vga_axil_master_fsm_sva

bind vga_axil_master_fsm vga_axil_master_fsm_sva u_sva (
  .clk_i     (clk_i),
  .arst_n_i  (arst_n_i),
  .awvalid   (r_awvalid),
  .awready   (w_awready),
  .wvalid    (r_wvalid),
  .wready    (w_wready),
  .arvalid   (r_arvalid),
  .arready   (w_arready),
  .bready    (w_bready),
  .rready    (w_rready),
  .addr      (r_addr),
  .data      (r_data),
  .rsp_valid (rsp_valid_o)
);
`default_nettype wire

// File: rtl/vga_axil_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_master_fsm
// Description : Single-outstanding AXI4-Lite initiator. Converts a native
//               valid/ready request into one AXI-Lite write or read and
//               returns a one-cycle completion pulse with the response.
// Ports       :
//   clk_i        in   sole clock (also clocks axil_if)
//   arst_n_i     in   asynchronous active-low reset
//   axil_if      mst  AXI-Lite initiator channels
//   req_valid_i  in   request valid
//   req_ready_o  out  request can be accepted (IDLE only)
//   req_write_i  in   1 = write, 0 = read
//   req_addr_i   in   byte address
//   req_data_i   in   write data
//   rsp_valid_o  out  one-cycle completion pulse
//   rsp_write_o  out  completed transaction was a write
//   rsp_data_o   out  read data (0 for writes)
//   rsp_resp_o   out  BRESP/RRESP, or SLVERR for a locally rejected request
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_master_fsm
  import vga_axil_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  vga_axil_if.master axil_if,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  axil_addr_t req_addr_i,
  input  axil_data_t req_data_i,
  output logic       rsp_valid_o,
  output logic       rsp_write_o,
  output axil_data_t rsp_data_o,
  output axil_resp_e rsp_resp_o
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    DONE         = 3'd5
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;

  logic       r_awvalid;
  logic       r_wvalid;
  logic       r_arvalid;
  axil_addr_t r_addr;
  axil_data_t r_data;

  logic       r_rsp_write;
  axil_data_t r_rsp_data;
  axil_resp_e r_rsp_resp;

  logic       w_awready;
  logic       w_wready;
  logic       w_bvalid;
  axil_resp_e w_bresp;
  logic       w_arready;
  logic       w_rvalid;
  axil_data_t w_rdata;
  axil_resp_e w_rresp;

  logic       w_req_ready;
  logic       w_rsp_valid;
  logic       w_bready;
  logic       w_rready;
  logic       w_misaligned;
  logic       w_aw_done;
  logic       w_w_done;

  // --------------------------------------------------------------------------
  // Slave-driven inputs
  // --------------------------------------------------------------------------
  assign w_awready = axil_if.awready;
  assign w_wready  = axil_if.wready;
  assign w_bvalid  = axil_if.bvalid;
  assign w_bresp   = axil_if.bresp;
  assign w_arready = axil_if.arready;
  assign w_rvalid  = axil_if.rvalid;
  assign w_rdata   = axil_if.rdata;
  assign w_rresp   = axil_if.rresp;

  // --------------------------------------------------------------------------
  // Local alignment check: sub-word byte offsets are refused without touching
  // the bus.
  // --------------------------------------------------------------------------
  if (CHECK_ALIGN != 0) begin : g_align_check
    assign w_misaligned = |req_addr_i[AXIL_WIDTH_OFFSET-1:0];
  end else begin : g_no_align_check
    assign w_misaligned = 1'b0;
  end

  // A channel counts as complete if it already handshook (valid dropped) or
  // handshakes this cycle; this covers AW and W finishing together.
  assign w_aw_done = ~r_awvalid | w_awready;
  assign w_w_done  = ~r_wvalid  | w_wready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_bready    = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid_i) begin
          if (w_misaligned) begin
            w_state_nxt = DONE;
          end else if (req_write_i) begin
            w_state_nxt = WR_ADDR_DATA;
          end else begin
            w_state_nxt = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (w_aw_done && w_w_done) begin
          w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        w_bready = 1'b1;
        if (w_bvalid) begin
          w_state_nxt = DONE;
        end
      end
      RD_ADDR: begin
        if (w_arready) begin
          w_state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        w_rready = 1'b1;
        if (w_rvalid) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_rsp_valid = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request capture, AXI valids and response capture. The rsp_*
  // registers load only on the way into DONE so they hold between pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rsp_write <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr <= req_addr_i;
            r_data <= req_data_i;
            if (w_misaligned) begin
              r_rsp_write <= req_write_i;
              r_rsp_data  <= '0;
              r_rsp_resp  <= RESP_SLVERR;
            end else if (req_write_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_arvalid <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (w_awready) begin
            r_awvalid <= 1'b0;
          end
          if (w_wready) begin
            r_wvalid <= 1'b0;
          end
        end
        WR_RESP: begin
          if (w_bvalid) begin
            r_rsp_write <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_resp  <= w_bresp;
          end
        end
        RD_ADDR: begin
          if (w_arready) begin
            r_arvalid <= 1'b0;
          end
        end
        RD_DATA: begin
          if (w_rvalid) begin
            r_rsp_write <= 1'b0;
            r_rsp_data  <= w_rdata;
            r_rsp_resp  <= w_rresp;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign axil_if.awvalid = r_awvalid;
  assign axil_if.awaddr  = r_addr;
  assign axil_if.awprot  = '0;
  assign axil_if.wvalid  = r_wvalid;
  assign axil_if.wdata   = r_data;
  assign axil_if.wstrb   = '1;
  assign axil_if.bready  = w_bready;
  assign axil_if.arvalid = r_arvalid;
  assign axil_if.araddr  = r_addr;
  assign axil_if.arprot  = '0;
  assign axil_if.rready  = w_rready;

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = w_rsp_valid;
  assign rsp_write_o = r_rsp_write;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_resp_o  = r_rsp_resp;

endmodule : vga_axil_master_fsm
`default_nettype wire

// File: tb/tb_vga_axil_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_axil_master_fsm
// Description : Self-checking bench for vga_axil_master_fsm with a memory
//               slave (programmable AWREADY delay, SLVERR on reads of 0x20,
//               optional B hold-off) and a queue-based response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_master_fsm;
  import vga_axil_pkg::*;

  logic       clk_i    = 1'b0;
  logic       arst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       req_valid_i = 1'b0;
  logic       req_write_i = 1'b0;
  axil_addr_t req_addr_i  = '0;
  axil_data_t req_data_i  = '0;
  logic       req_ready_o;
  logic       rsp_valid_o;
  logic       rsp_write_o;
  axil_data_t rsp_data_o;
  axil_resp_e rsp_resp_o;

  vga_axil_if u_if ();

  vga_axil_master_fsm #(.CHECK_ALIGN(1)) u_dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .axil_if     (u_if),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_write_o (rsp_write_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_resp_o  (rsp_resp_o)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Slave model
  // --------------------------------------------------------------------------
  int         aw_delay = 0;
  int         aw_wait;
  bit         b_hold = 1'b0;
  logic       aw_got, w_got;
  axil_addr_t s_wa;
  axil_data_t s_wd;
  logic       s_bvalid, s_rvalid;
  axil_data_t s_rdata;
  axil_resp_e s_rresp;
  axil_data_t mem [16];
  logic       s_aw_hs, s_w_hs, s_wr_ready;
  axil_addr_t s_wr_addr;
  axil_data_t s_wr_data;

  assign u_if.awready = (aw_wait + 1 >= aw_delay);
  assign u_if.wready  = 1'b1;
  assign u_if.arready = 1'b1;
  assign u_if.bvalid  = s_bvalid;
  assign u_if.bresp   = RESP_OKAY;
  assign u_if.rvalid  = s_rvalid;
  assign u_if.rdata   = s_rdata;
  assign u_if.rresp   = s_rresp;

  assign s_aw_hs    = u_if.awvalid & u_if.awready;
  assign s_w_hs     = u_if.wvalid & u_if.wready;
  assign s_wr_ready = (aw_got | s_aw_hs) & (w_got | s_w_hs);
  assign s_wr_addr  = aw_got ? s_wa : u_if.awaddr;
  assign s_wr_data  = w_got ? s_wd : u_if.wdata;

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      aw_wait  <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      s_wa     <= '0;
      s_wd     <= '0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (s_aw_hs) begin
        aw_got  <= 1'b1;
        s_wa    <= u_if.awaddr;
        aw_wait <= 0;
      end else if (u_if.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (s_w_hs) begin
        w_got <= 1'b1;
        s_wd  <= u_if.wdata;
      end
      if (s_bvalid && u_if.bready) s_bvalid <= 1'b0;
      if (s_wr_ready && !s_bvalid && !b_hold) begin
        s_bvalid                <= 1'b1;
        mem[s_wr_addr[5:2]]     <= s_wr_data;
        aw_got                  <= 1'b0;
        w_got                   <= 1'b0;
      end
      if (s_rvalid && u_if.rready) s_rvalid <= 1'b0;
      if (u_if.arvalid && u_if.arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[u_if.araddr[5:2]];
        s_rresp  <= (u_if.araddr == 32'h20) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard and bus monitor (sampled on the falling edge)
  // --------------------------------------------------------------------------
  typedef struct {
    logic       wr;
    axil_data_t data;
    logic [1:0] resp;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       sb_q [$];
  axil_addr_t cur_addr = '0;
  axil_data_t cur_data = '0;
  int aw_cycles = 0, w_cycles = 0, ar_cycles = 0, b_hs = 0, rsp_count = 0;

  always @(negedge clk_i) begin : mon
    exp_t e;
    if (arst_n_i) begin
      if (u_if.awvalid) begin
        aw_cycles++;
        check("awaddr", 64'(u_if.awaddr), 64'(cur_addr));
        check("awprot", 64'(u_if.awprot), 64'd0);
      end
      if (u_if.wvalid) begin
        w_cycles++;
        check("wdata", 64'(u_if.wdata), 64'(cur_data));
        check("wstrb", 64'(u_if.wstrb), 64'hF);
      end
      if (u_if.arvalid) begin
        ar_cycles++;
        check("araddr", 64'(u_if.araddr), 64'(cur_addr));
        check("arprot", 64'(u_if.arprot), 64'd0);
      end
      if (s_bvalid && u_if.bready) b_hs++;
      if (rsp_valid_o) begin
        rsp_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_write", 64'(rsp_write_o), 64'(e.wr));
          check("rsp_data", 64'(rsp_data_o), 64'(e.data));
          check("rsp_resp", 64'(rsp_resp_o), 64'(e.resp));
          if (e.lat > 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  axil_data_t shadow [16];

  task automatic send(input logic wr, input axil_addr_t a, input axil_data_t d,
                      input logic [1:0] eresp, input axil_data_t edata,
                      input int lat, input bit push);
    exp_t e;
    int   n;
    @(negedge clk_i);
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("req_ready", 64'(req_ready_o), 64'd1);
    cur_addr    = a;
    cur_data    = d;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = a;
    req_data_i  = d;
    if (push) begin
      e.wr = wr; e.data = edata; e.resp = eresp; e.acc = cyc; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check("rsp_received", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_write(input axil_addr_t a, input axil_data_t d);
    int lat;
    lat = (aw_delay <= 1) ? 3 : aw_delay + 2;
    shadow[a[5:2]] = d;
    send(1'b1, a, d, RESP_OKAY, '0, lat, 1'b1);
    wait_done();
  endtask

  task automatic do_read(input axil_addr_t a);
    send(1'b0, a, '0, (a == 32'h20) ? RESP_SLVERR : RESP_OKAY, shadow[a[5:2]], 3, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int aw0, w0, b0, ar0, r0, idx;
    axil_addr_t a;

    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_write", 64'(rsp_write_o), 64'd0);
    check("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    check("rst_rsp_resp", 64'(rsp_resp_o), 64'(RESP_OKAY));
    check("rst_awvalid", 64'(u_if.awvalid), 64'd0);
    check("rst_wvalid", 64'(u_if.wvalid), 64'd0);
    check("rst_arvalid", 64'(u_if.arvalid), 64'd0);
    check("rst_bready", 64'(u_if.bready), 64'd0);
    check("rst_rready", 64'(u_if.rready), 64'd0);
    check("rst_awaddr", 64'(u_if.awaddr), 64'd0);
    check("rst_wdata", 64'(u_if.wdata), 64'd0);
    arst_n_i = 1'b1;

    // Basic write, always-ready slave
    b0 = b_hs;
    do_write(32'h10, 32'hDEADBEEF);
    check("slave_awaddr", 64'(s_wa), 64'h10);
    check("slave_wdata", 64'(s_wd), 64'hDEADBEEF);
    check("b_count_basic", 64'(b_hs - b0), 64'd1);

    // Read back
    do_read(32'h10);

    // AWREADY delayed 4 cycles, WREADY immediate
    aw_delay = 4;
    aw0 = aw_cycles; w0 = w_cycles; b0 = b_hs;
    do_write(32'h14, 32'h12345678);
    check("aw_valid_cycles", 64'(aw_cycles - aw0), 64'd4);
    check("w_valid_cycles", 64'(w_cycles - w0), 64'd1);
    check("b_count_delay", 64'(b_hs - b0), 64'd1);
    aw_delay = 0;

    // Misaligned read and write are refused locally
    ar0 = ar_cycles;
    send(1'b0, 32'h13, '0, RESP_SLVERR, '0, 1, 1'b1);
    wait_done();
    check("misaligned_no_ar", 64'(ar_cycles - ar0), 64'd0);
    aw0 = aw_cycles; w0 = w_cycles;
    send(1'b1, 32'h11, 32'h55, RESP_SLVERR, '0, 1, 1'b1);
    wait_done();
    check("misaligned_no_aw", 64'(aw_cycles - aw0), 64'd0);
    check("misaligned_no_w", 64'(w_cycles - w0), 64'd0);

    // Slave error on read of 0x20
    do_write(32'h20, 32'hCAFEF00D);
    do_read(32'h20);

    // Mixed traffic with varying AWREADY delay
    for (int i = 0; i < 12; i++) begin
      idx      = int'($urandom_range(0, 8));
      a        = axil_addr_t'(idx) << 2;
      aw_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_write(a, axil_data_t'($urandom));
      else do_read(a);
    end
    aw_delay = 0;

    // Reset while waiting in WR_RESP aborts with no response
    b_hold = 1'b1;
    r0 = rsp_count;
    send(1'b1, 32'h18, 32'h0BADF00D, RESP_OKAY, '0, 0, 1'b0);
    idx = 0;
    while (!u_if.bready && idx < 20) begin
      @(negedge clk_i);
      idx++;
    end
    check("reached_wr_resp", 64'(u_if.bready), 64'd1);
    arst_n_i = 1'b0;
    #1;
    check("abort_awvalid", 64'(u_if.awvalid), 64'd0);
    check("abort_wvalid", 64'(u_if.wvalid), 64'd0);
    check("abort_arvalid", 64'(u_if.arvalid), 64'd0);
    check("abort_bready", 64'(u_if.bready), 64'd0);
    check("abort_rready", 64'(u_if.rready), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("abort_req_ready", 64'(req_ready_o), 64'd1);
    check("abort_awaddr", 64'(u_if.awaddr), 64'd0);
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    b_hold   = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    check("abort_no_rsp", 64'(rsp_count - r0), 64'd0);

    // Traffic resumes normally after the abort
    do_write(32'h18, 32'hA5A55A5A);
    do_read(32'h18);
    do_read(32'h10);

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vga_axil_master_fsm
`default_nettype wire
